seletor_fun_seq: RTL and testbench
==================================

SELETOR_FUN_SEQ -- requirements
Module: seletor_fun_seq

Interface
REQ-001 SHALL have parameter N_IN, default 6, meaning width of condition input vector.
REQ-002 SHALL have parameter N_FUN, default 3, meaning number of selectable functions (output channels).
REQ-003 SHALL have parameter STABLE, default 4, meaning consecutive equal-sample cycles required before evaluation (legal range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cond  input  N_IN  raw condition inputs, sampled every cycle.
REQ-007 SHALL have port cfg_we  input  1  write strobe for one function's match rule.
REQ-008 SHALL have port cfg_idx  input  clog2(N_FUN)  function index written.
REQ-009 SHALL have port cfg_care  input  N_IN  care mask for rule.
REQ-010 SHALL have port cfg_val  input  N_IN  required values on care bits.
REQ-011 SHALL have port sel  output  N_FUN  registered one-hot selected function.
REQ-012 SHALL have port sel_valid  output  1  sel is valid.
REQ-013 SHALL have port sel_ack  input  1  consumer accepts sel.
REQ-014 SHALL have port match  output  N_FUN  registered raw match vector of last evaluation.

Function
REQ-015 Function k SHALL match when care_k != 0 and (cond_s & care_k) == (cfg_val_k & care_k), where cond_s is the registered sample of cond.
REQ-016 Stability counter SHALL reset to 0 whenever cond_s differs from previous sample, increment otherwise, and saturate at STABLE; "stable" = counter == STABLE.
REQ-017 FSM states: IDLE, VALID, HOLD.
REQ-018 IDLE: when stable and any function matches, SHALL load sel with one-hot of lowest-index match, load match, go to VALID next cycle; else remain IDLE with sel_valid=0.
REQ-019 VALID: sel_valid=1; sel and match SHALL stay constant regardless of cond or cfg changes until handshake.
REQ-020 Handshake completes in the cycle where sel_valid=1 and sel_ack=1; next cycle SHALL be HOLD with sel_valid=0, sel cleared to 0.
REQ-021 HOLD: SHALL wait until cond_s changes (counter returns to 0), then go to IDLE; identical unchanged input SHALL never produce a second selection.
REQ-022 sel_ack while not VALID SHALL be ignored.
REQ-023 cfg write for index >= N_FUN SHALL be ignored; a valid write takes effect from the next cycle's evaluation and never alters a pending sel.
REQ-024 Write to function k simultaneous with an IDLE evaluation SHALL evaluate with the old rule.
REQ-025 Latency: cond change held constant → sel_valid high exactly STABLE+2 cycles after first cycle cond presents the new value (1 sample + STABLE + 1 register).
REQ-026 Multiple matches SHALL select lowest index; match reports all.

Reset
REQ-027 With rst=1 at a rising edge: state=IDLE, sel=0, sel_valid=0, match=0, counter=0, all care masks and values=0 (no function can match).
REQ-028 Reset mid-handshake SHALL drop sel_valid next cycle with no ack required; sample register also clears to 0.

Structure
REQ-029 Shared package seletor_pkg SHALL hold the FSM state enum (IDLE, VALID, HOLD) and default parameter constants.
REQ-030 Stability detect SHALL be sub-module seletor_estavel (sample register, compare, saturating counter, stable output).
REQ-031 Rule storage and priority encode SHALL be inside seletor_fun_seq.

Verification
REQ-032 Reset, then rule0 care=6'b000101 val=6'b000101, cond=6'b000101 held → sel_valid high after 6 cycles (STABLE=4), sel=3'b001, match=3'b001.
REQ-033 Rules 0,1,2 all matching cond=6'b111111 → sel=3'b001, match=3'b111.
REQ-034 sel_valid high, ack low for 10 cycles while cond toggles → sel constant; ack=1 → next cycle sel_valid=0, sel=0; same cond held → no new valid.
REQ-035 cond toggling every 2 cycles → sel_valid never asserted; then held → valid after STABLE+2.
REQ-036 cfg write rule1 during VALID with cfg_idx=3 (N_FUN=3) → no change to sel or any rule.
REQ-037 rst pulse while VALID → next cycle sel_valid=0, sel=0, match=0; matching cond no longer matches (rules cleared).

Source files
------------

// File: rtl/seletor_pkg.sv
// Shared definitions for the condition-driven function selector.
// Holds the selector FSM state encoding and the default sizing constants.
// Counter width is fixed wide enough for any legal stability window.
package seletor_pkg;

  localparam int DEF_N_IN   = 6;
  localparam int DEF_N_FUN  = 3;
  localparam int DEF_STABLE = 4;

  // Stability window is limited to 1..255, so an 8-bit counter always suffices.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/seletor_estavel.sv
// Stability detector: registers the raw condition vector and counts how many
// consecutive cycles the registered sample has stayed unchanged, saturating at
// STABLE. stable_o marks a settled input, changed_o marks a freshly changed one.
module seletor_estavel
  import seletor_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int STABLE = DEF_STABLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] cond_i,
  output logic [N_IN-1:0] cond_s_o,
  output logic            stable_o,
  output logic            changed_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE);

  logic [N_IN-1:0]  samp_q, samp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The incoming value is compared with the current sample so the counter
  // restarts on the same edge that captures a new sample value.
  always_comb begin
    samp_d = cond_i;
    cnt_d  = cnt_q;
    if (cond_i != samp_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sample and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cond_s_o  = samp_q;
  assign stable_o  = (cnt_q == CNT_MAX);
  assign changed_o = (cnt_q == '0);

endmodule

// File: rtl/seletor_fun_seq.sv
// Selects the lowest-index function whose care/value rule matches a settled
// condition vector; sel_valid rises STABLE+2 cycles after a new input value.
// sel/match hold until sel_ack; afterwards a changed input is needed to rearm.
module seletor_fun_seq
  import seletor_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_FUN  = DEF_N_FUN,
  parameter int STABLE = DEF_STABLE
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_IN-1:0]                              cond,
  input  logic                                         cfg_we,
  input  logic [((N_FUN > 1) ? $clog2(N_FUN) : 1)-1:0] cfg_idx,
  input  logic [N_IN-1:0]                              cfg_care,
  input  logic [N_IN-1:0]                              cfg_val,
  output logic [N_FUN-1:0]                             sel,
  output logic                                         sel_valid,
  input  logic                                         sel_ack,
  output logic [N_FUN-1:0]                             match
);

  logic [N_IN-1:0]  cond_s;
  logic             stable;
  logic             changed;

  logic [N_IN-1:0]  care_q [N_FUN];
  logic [N_IN-1:0]  val_q  [N_FUN];

  logic [N_FUN-1:0] hit;
  logic [N_FUN-1:0] first_hit;
  logic             found;

  state_e           state_q, state_d;
  logic [N_FUN-1:0] sel_q, sel_d;
  logic [N_FUN-1:0] match_q, match_d;

  seletor_estavel #(
    .N_IN   (N_IN),
    .STABLE (STABLE)
  ) u_estavel (
    .clk       (clk),
    .rst       (rst),
    .cond_i    (cond),
    .cond_s_o  (cond_s),
    .stable_o  (stable),
    .changed_o (changed)
  );

  // Rule storage: an out-of-range index matches no slot and is dropped. A
  // write lands on the same edge as any concurrent evaluation, which therefore
  // still sees the previous rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_FUN; k++) begin
        care_q[k] <= '0;
        val_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_FUN; k++) begin
        if (cfg_we && (int'(cfg_idx) == k)) begin
          care_q[k] <= cfg_care;
          val_q[k]  <= cfg_val;
        end
      end
    end
  end

  // Rule match per function; an all-zero care mask never matches.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_FUN; k++) begin
      hit[k] = (care_q[k] != '0) &&
               ((cond_s & care_q[k]) == (val_q[k] & care_q[k]));
    end
  end

  // Priority encode: one-hot of the lowest-index match.
  always_comb begin
    first_hit = '0;
    found     = 1'b0;
    for (int k = 0; k < N_FUN; k++) begin
      if (hit[k] && !found) begin
        first_hit[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Selector FSM next state: capture once on a settled match, hold until the
  // handshake, then wait for the sampled input to change before rearming.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (stable && found) begin
          sel_d   = first_hit;
          match_d = hit;
          state_d = VALID;
        end
      end
      VALID: begin
        if (sel_ack) begin
          sel_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Selector FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      match_q <= match_d;
    end
  end

  assign sel       = sel_q;
  assign match     = match_q;
  assign sel_valid = (state_q == VALID);

endmodule

// File: tb/tb_seletor_fun_seq.sv
// Directed bench for seletor_fun_seq with default sizing (6 inputs, 3 functions, STABLE=4).
// Vector table plus hand-written sequences; outputs are sampled 1 time unit after each rising edge.
// Every expected value is hand-computed.
module tb_seletor_fun_seq;

  logic       clk;
  logic       rst;
  logic [5:0] cond;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [5:0] cfg_care;
  logic [5:0] cfg_val;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_ack;
  logic [2:0] match;

  int nvec;
  int nerr;

  typedef struct packed {
    logic       rst;
    logic [5:0] cond;
    logic       we;
    logic [1:0] idx;
    logic [5:0] care;
    logic [5:0] val;
    logic       ack;
    logic [7:0] n;      // cycles to apply these inputs
    logic       every;  // check after every cycle, not only the last
    logic       vld;
    logic [2:0] sel;
    logic [2:0] match;
  } vec_t;

  vec_t tbl[$];

  seletor_fun_seq #(
    .N_IN   (6),
    .N_FUN  (3),
    .STABLE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cond      (cond),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ack   (sel_ack),
    .match     (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic ev, input logic [2:0] es,
                       input logic [2:0] em);
    nvec++;
    if (sel_valid !== ev || sel !== es || match !== em) begin
      nerr++;
      $display("FAIL %s: got vld=%0b sel=%b match=%b, want vld=%0b sel=%b match=%b",
               nm, sel_valid, sel, match, ev, es, em);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] c, input logic w, input logic [1:0] ix,
                     input logic [5:0] ca, input logic [5:0] va, input logic a,
                     input int n, input logic ev, input logic ve, input logic [2:0] se,
                     input logic [2:0] ma);
    vec_t v;
    v.rst = r; v.cond = c; v.we = w; v.idx = ix; v.care = ca; v.val = va; v.ack = a;
    v.n = 8'(n); v.every = ev; v.vld = ve; v.sel = se; v.match = ma;
    tbl.push_back(v);
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    rst      = 1'b1;
    cond     = '0;
    cfg_we   = 1'b0;
    cfg_idx  = '0;
    cfg_care = '0;
    cfg_val  = '0;
    sel_ack  = 1'b0;

    //  rst cond       we idx care       val        ack n  every vld sel     match
    // reset state
    add(1, 6'b000000, 0, 0, 6'b000000, 6'b000000, 0, 2, 1, 0, 3'b000, 3'b000);
    // rule0 = care 000101 / val 000101
    add(0, 6'b000000, 1, 0, 6'b000101, 6'b000101, 0, 1, 1, 0, 3'b000, 3'b000);
    // new cond: low for STABLE+1 edges, valid on edge STABLE+2
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 0, 5, 1, 0, 3'b000, 3'b000);
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 1, 3'b001, 3'b001);
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 0, 3, 1, 1, 3'b001, 3'b001);
    // out-of-range write (idx 3) during VALID: ignored
    add(0, 6'b000101, 1, 3, 6'b111111, 6'b000000, 0, 1, 1, 1, 3'b001, 3'b001);
    // legal write of rule1 during VALID: pending sel untouched
    add(0, 6'b000101, 1, 1, 6'b110000, 6'b110000, 0, 1, 1, 1, 3'b001, 3'b001);
    // handshake, then same cond held: no second selection; stray acks ignored
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 1, 1, 1, 0, 3'b000, 3'b001);
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 0, 12, 1, 0, 3'b000, 3'b001);
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 1, 2, 1, 0, 3'b000, 3'b001);
    // rule2 = 001111 / 001111; then all three rules match 111111
    add(0, 6'b000101, 1, 2, 6'b001111, 6'b001111, 0, 1, 1, 0, 3'b000, 3'b001);
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 0, 5, 1, 0, 3'b000, 3'b001);
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 1, 3'b001, 3'b111);
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 1, 1, 1, 0, 3'b000, 3'b111);
    // rule0 rewritten on the evaluation edge: old rule still decides
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 0, 5, 1, 0, 3'b000, 3'b111);
    add(0, 6'b000101, 1, 0, 6'b000101, 6'b000000, 0, 1, 1, 1, 3'b001, 3'b001);
    add(0, 6'b000101, 0, 0, 6'b000000, 6'b000000, 1, 1, 1, 0, 3'b000, 3'b001);
    // new rule0 rejects 111111: rules 1 and 2 win, lowest is 1
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 0, 5, 1, 0, 3'b000, 3'b001);
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 1, 3'b010, 3'b110);
    add(0, 6'b111111, 0, 0, 6'b000000, 6'b000000, 1, 1, 1, 0, 3'b000, 3'b110);
    // 110000 matches rule0 (care 000101 / val 0) and rule1
    add(0, 6'b110000, 0, 0, 6'b000000, 6'b000000, 0, 5, 1, 0, 3'b000, 3'b110);
    add(0, 6'b110000, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 1, 3'b001, 3'b011);

    foreach (tbl[i]) begin
      rst      = tbl[i].rst;
      cond     = tbl[i].cond;
      cfg_we   = tbl[i].we;
      cfg_idx  = tbl[i].idx;
      cfg_care = tbl[i].care;
      cfg_val  = tbl[i].val;
      sel_ack  = tbl[i].ack;
      for (int c = 0; c < int'(tbl[i].n); c++) begin
        cyc();
        if (tbl[i].every || c == int'(tbl[i].n) - 1)
          check($sformatf("vec%0d.c%0d", i, c), tbl[i].vld, tbl[i].sel, tbl[i].match);
      end
    end
    cfg_we  = 1'b0;
    sel_ack = 1'b0;

    // Held VALID with ack low while cond toggles: selection frozen.
    for (int i = 0; i < 10; i++) begin
      cond = (i % 2 == 0) ? 6'b000000 : 6'b111111;
      cyc();
      check($sformatf("frozen%0d", i), 1'b1, 3'b001, 3'b011);
    end
    cond = 6'b110000;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check($sformatf("frozen_tail%0d", i), 1'b1, 3'b001, 3'b011);
    end
    sel_ack = 1'b1;
    cyc();
    check("ack_after_toggle", 1'b0, 3'b000, 3'b011);
    sel_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check($sformatf("no_rearm%0d", i), 1'b0, 3'b000, 3'b011);
    end

    // Matching inputs toggling every 2 cycles never settle.
    for (int i = 0; i < 8; i++) begin
      cond = (i % 2 == 0) ? 6'b001111 : 6'b110000;
      for (int c = 0; c < 2; c++) begin
        cyc();
        check($sformatf("toggle%0d.%0d", i, c), 1'b0, 3'b000, 3'b011);
      end
    end
    cond = 6'b001111;
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("settle%0d", c), 1'b0, 3'b000, 3'b011);
    end
    cyc();
    check("settle_valid", 1'b1, 3'b100, 3'b100);

    // Reset while VALID: outputs and rules cleared, no ack needed.
    rst = 1'b1;
    cyc();
    check("rst_mid_valid", 1'b0, 3'b000, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      check($sformatf("rules_cleared%0d", c), 1'b0, 3'b000, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
